// File: rtl/spi_ram_ctrl.sv
// Command decoder and RAM owner behind the SPI slave: write/read address registers, sticky error flag.
// Optional build macro SPI_RAM_AUTO_INC_EN enables address auto-increment after data commands.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    input  logic       err_clr,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    // state | meaning
    // IDLE  | no read in flight, tx_valid low
    // FETCH | one cycle: capture mem[rd_addr] into dout
    // HOLD  | dout valid, tx_valid high until the next accepted command
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    state_t                 state_q, state_d;
    logic                   rx_valid_q;
    logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
    logic                   wr_addr_ok_q, wr_addr_ok_d;
    logic                   rd_addr_ok_q, rd_addr_ok_d;
    logic                   cmd_err_q, cmd_err_d;
    logic [7:0]             dout_q, dout_d;
    logic [7:0]             mem [MEM_DEPTH];

    logic                   accept;
    logic [1:0]             opcode;
    logic [7:0]             payload;
    logic                   addr_in_range;
    logic                   mem_we;
    logic                   err_set;

    assign accept        = rx_valid & ~rx_valid_q;
    assign opcode        = din[9:8];
    assign payload       = din[7:0];
    assign addr_in_range = (32'(payload) < MEM_DEPTH);

`ifdef SPI_RAM_AUTO_INC_EN
    function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
        return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_ok_d = wr_addr_ok_q;
        rd_addr_ok_d = rd_addr_ok_q;
        dout_d       = dout_q;
        mem_we       = 1'b0;
        err_set      = 1'b0;

        case (state_q)
            FETCH: begin
                dout_d  = mem[rd_addr_q[IDX_W-1:0]];
                state_d = HOLD;
`ifdef SPI_RAM_AUTO_INC_EN
                rd_addr_d = next_addr(rd_addr_q);
`endif
            end
            HOLD: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Command decode; a read-data accept overrides the HOLD->IDLE exit above.
        if (accept) begin
            case (opcode)
                2'b00: begin
                    if (addr_in_range) begin
                        wr_addr_d    = ADDR_SIZE'(payload);
                        wr_addr_ok_d = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                2'b01: begin
                    if (wr_addr_ok_q) begin
                        mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                        wr_addr_d = next_addr(wr_addr_q);
`endif
                    end else begin
                        err_set = 1'b1;
                    end
                end
                2'b10: begin
                    if (addr_in_range) begin
                        rd_addr_d    = ADDR_SIZE'(payload);
                        rd_addr_ok_d = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                default: begin
                    if (rd_addr_ok_q) begin
                        state_d = FETCH;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            endcase
        end

        cmd_err_d = err_set | (cmd_err_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rx_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_addr_ok_q <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            cmd_err_q    <= 1'b0;
            dout_q       <= 8'h00;
        end else begin
            state_q      <= state_d;
            rx_valid_q   <= rx_valid;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_ok_q <= wr_addr_ok_d;
            rd_addr_ok_q <= rd_addr_ok_d;
            cmd_err_q    <= cmd_err_d;
            dout_q       <= dout_d;
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q[IDX_W-1:0]] <= payload;
        end
    end

    assign dout     = dout_q;
    assign tx_valid = (state_q == HOLD);
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl (MEM_DEPTH=200): directed scenarios plus randomized command traffic.
module tb_spi_ram_ctrl;

    localparam int DEPTH = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] din;
    logic       rx_valid;
    logic       err_clr;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    int errors = 0;
    int checks = 0;
    bit rand_mode = 0;

    spi_ram_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .err_clr  (err_clr),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    // Reference model: memory image plus what the outputs must show after each edge.
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] m_wr, m_rd, m_dout;
    bit         m_wok, m_rok, m_err, m_tx, m_fetch, m_dk, m_rxq;

    always @(posedge clk or negedge rst_n) begin : ref_model
        logic [7:0] wr, rd, dv, pay;
        logic [1:0] op;
        bit wok, rok, tx, fetch, dk, set, acc;
        if (!rst_n) begin
            m_rxq <= 0; m_wr <= 0; m_rd <= 0; m_wok <= 0; m_rok <= 0;
            m_err <= 0; m_tx <= 0; m_fetch <= 0; m_dout <= 0; m_dk <= 1;
        end else begin
            wr = m_wr; rd = m_rd; wok = m_wok; rok = m_rok; tx = m_tx;
            fetch = m_fetch; dv = m_dout; dk = m_dk; set = 0;
            acc = rx_valid && !m_rxq;
            op  = din[9:8];
            pay = din[7:0];
            if (fetch) begin
                fetch = 0;
                dv = m_mem[rd];
                dk = m_known[rd];
                tx = 1;
`ifdef SPI_RAM_AUTO_INC_EN
                rd = 8'((int'(rd) + 1) % DEPTH);
`endif
            end
            if (acc) begin
                tx = 0;
                case (op)
                    2'd0: if (int'(pay) < DEPTH) begin wr = pay; wok = 1; end else set = 1;
                    2'd1: if (wok) begin
                              m_mem[wr]   <= pay;
                              m_known[wr] <= 1;
`ifdef SPI_RAM_AUTO_INC_EN
                              wr = 8'((int'(wr) + 1) % DEPTH);
`endif
                          end else set = 1;
                    2'd2: if (int'(pay) < DEPTH) begin rd = pay; rok = 1; end else set = 1;
                    default: if (rok) fetch = 1; else set = 1;
                endcase
            end
            m_rxq <= rx_valid; m_wr <= wr; m_rd <= rd; m_wok <= wok; m_rok <= rok;
            m_tx <= tx; m_fetch <= fetch; m_dout <= dv; m_dk <= dk;
            m_err <= set ? 1'b1 : (err_clr ? 1'b0 : m_err);
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, well clear of both clock edges.
    always @(posedge clk) begin
        #2;
        chk("tx_valid", {7'd0, tx_valid}, {7'd0, m_tx});
        chk("cmd_err", {7'd0, cmd_err}, {7'd0, m_err});
        if (m_dk) chk("dout", dout, m_dout);
    end

    task automatic tick();
        if (rand_mode) err_clr = ($urandom_range(0, 7) == 0);
        @(negedge clk);
    endtask

    task automatic send(input logic [9:0] cmd, input int hold, input int gap);
        din = cmd;
        rx_valid = 1'b1;
        repeat (hold) tick();
        rx_valid = 1'b0;
        din = 10'($urandom);
        repeat (gap) tick();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; din = '0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset dout", dout, 8'h00);
        chk("reset tx_valid", {7'd0, tx_valid}, 8'h00);
        chk("reset cmd_err", {7'd0, cmd_err}, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Read-data with no read address, then write-data with no write address
        send(10'h300, 1, 1);
        chk("seq err read", {7'd0, cmd_err}, 8'h01);
        chk("seq err no tx", {7'd0, tx_valid}, 8'h00);
        clear_err();
        chk("err_clr", {7'd0, cmd_err}, 8'h00);
        send(10'h1FF, 1, 1);
        chk("seq err write", {7'd0, cmd_err}, 8'h01);
        clear_err();

        // Write then read back
        send(10'h005, 1, 1); send(10'h1A5, 1, 1); send(10'h205, 1, 1); send(10'h300, 1, 1);
        chk("readback dout", dout, 8'hA5);
        chk("readback tx", {7'd0, tx_valid}, 8'h01);
        repeat (3) @(negedge clk);
        chk("hold tx", {7'd0, tx_valid}, 8'h01);
        chk("hold dout", dout, 8'hA5);

        // Range check at depth 200
        send(10'h00A, 1, 1);
        chk("tx drops on accept", {7'd0, tx_valid}, 8'h00);
        chk("no err in range", {7'd0, cmd_err}, 8'h00);
        send(10'h0C8, 1, 1);
        chk("range err", {7'd0, cmd_err}, 8'h01);
        send(10'h133, 1, 1); send(10'h20A, 1, 1); send(10'h300, 1, 1);
        chk("range readback", dout, 8'h33);

        // Level held for five cycles gives one accept
        send(10'h010, 1, 1); send(10'h144, 5, 1); send(10'h155, 1, 1);
        send(10'h210, 1, 1); send(10'h300, 1, 1);
`ifdef SPI_RAM_AUTO_INC_EN
        chk("level hold first", dout, 8'h44);
        send(10'h300, 1, 1);
        chk("level hold second", dout, 8'h55);
        // Wrap at MEM_DEPTH-1
        send(10'h0C7, 1, 1); send(10'h111, 1, 1); send(10'h122, 1, 1);
        send(10'h2C7, 1, 1); send(10'h300, 1, 1);
        chk("wrap read top", dout, 8'h11);
        send(10'h300, 1, 1);
        chk("wrap read zero", dout, 8'h22);
`else
        chk("level hold overwrite", dout, 8'h55);
`endif

        // Reset in the middle of HOLD with the error flag set
        send(10'h0FF, 1, 1);
        send(10'h300, 1, 1);
        chk("pre-reset tx", {7'd0, tx_valid}, 8'h01);
        chk("pre-reset err", {7'd0, cmd_err}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("async reset tx", {7'd0, tx_valid}, 8'h00);
        chk("async reset err", {7'd0, cmd_err}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset dout", dout, 8'h00);

        // Randomized traffic
        rand_mode = 1;
        for (int n = 0; n < 600; n++) begin
            logic [1:0] op;
            logic [7:0] a;
            int h;
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = 8'($urandom_range(0, 255));
                1:       a = 8'($urandom_range(DEPTH - 4, DEPTH - 1));
                default: a = 8'($urandom_range(0, 15));
            endcase
            h = $urandom_range(1, 4);
            if ($urandom_range(0, 39) == 0) begin
                send({op, a}, h, 0);
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                tick();
            end else begin
                send({op, a}, h, $urandom_range(1, 3));
            end
        end
        err_clr = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
